// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg: shared RV32 format enum, opcode constants and immediate-range helper.
// Used by the immediate generator and by inst_encoder; no ports.
package inst_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } entry_t;

    // True when v is representable as a signed value of the given bit width:
    // everything above the sign bit must be a copy of it.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic signed [31:0] s;
        s = $signed(v) >>> (bits - 1);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/inst_encoder_sync_fifo.sv
// sync_fifo: power-of-two depth FIFO with combinational head read.
// Ports: clk, rst_n (async, active-low); push/wdata write side; pop/rdata read side;
// full, empty, level occupancy. rdata reads zero while empty.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop) rptr <= rptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32 instruction fields into words, range-checks immediates, buffers results.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready with in_fmt and raw fields in;
// out_valid/out_ready with out_inst, out_addr; err_range pulse, err_count, fifo_level.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    in_fmt,
    input  logic [6:0]                    in_opcode,
    input  logic [4:0]                    in_rd,
    input  logic [4:0]                    in_rs1,
    input  logic [4:0]                    in_rs2,
    input  logic [2:0]                    in_funct3,
    input  logic [6:0]                    in_funct7,
    input  logic [31:0]                   in_imm,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_inst,
    output logic [31:0]                   out_addr,
    output logic                          err_range,
    output logic [7:0]                    err_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    logic [31:0] inst, addr_q;
    logic        ok, accept, full, empty;
    entry_t      wdata, rdata;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign wdata     = '{addr: addr_q, inst: inst};
    assign out_inst  = rdata.inst;
    assign out_addr  = rdata.addr;

    always_comb begin
        inst = '0;
        ok   = 1'b0;
        case (in_fmt)
            FMT_R: begin
                inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                ok   = 1'b1;
            end
            FMT_I: begin
                inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                ok   = fits_signed(in_imm, 12);
            end
            FMT_S: begin
                inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                ok   = fits_signed(in_imm, 12);
            end
            FMT_B: begin
                inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode};
                ok   = fits_signed(in_imm, 13) && !in_imm[0];
            end
            FMT_U: begin
                inst = {in_imm[31:12], in_rd, in_opcode};
                ok   = in_imm[11:0] == '0;
            end
            FMT_J: begin
                inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                ok   = fits_signed(in_imm, 21) && !in_imm[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= BASE_ADDR;
            err_range <= 1'b0;
            err_count <= '0;
        end else begin
            err_range <= accept && !ok;
            if (accept && ok) addr_q <= addr_q + 32'd4;
            if (accept && !ok && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept && ok),
        .wdata (wdata),
        .pop   (out_valid && out_ready),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed and randomized checks of inst_encoder against a field-decoding reference model.
module tb_inst_encoder;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, err_range;
    logic [2:0]  in_fmt = '0, in_funct3 = '0;
    logic [6:0]  in_opcode = '0, in_funct7 = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0, out_inst, out_addr;
    logic [7:0]  err_count;
    logic [2:0]  fifo_level;

    int checks = 0, failures = 0;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fields_t;

    typedef struct {
        logic [2:0]  fmt;
        fields_t     f;
        logic [31:0] addr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_addr = 0;
    int          m_cnt = 0;
    bit          m_pulse = 0;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_addr   (out_addr),
        .err_range  (err_range),
        .err_count  (err_count),
        .fifo_level (fifo_level)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Immediate-generator view of a word: recover the fields each format carries.
    function automatic fields_t decode(input logic [31:0] w, input logic [2:0] fmt);
        fields_t f;
        f = '0;
        f.op = w[6:0];
        case (fmt)
            3'd0: begin f.rd = w[11:7]; f.f3 = w[14:12]; f.rs1 = w[19:15]; f.rs2 = w[24:20]; f.f7 = w[31:25]; end
            3'd1: begin f.rd = w[11:7]; f.f3 = w[14:12]; f.rs1 = w[19:15]; f.imm = {{20{w[31]}}, w[31:20]}; end
            3'd2: begin f.f3 = w[14:12]; f.rs1 = w[19:15]; f.rs2 = w[24:20]; f.imm = {{20{w[31]}}, w[31:25], w[11:7]}; end
            3'd3: begin f.f3 = w[14:12]; f.rs1 = w[19:15]; f.rs2 = w[24:20]; f.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0}; end
            3'd4: begin f.rd = w[11:7]; f.imm = {w[31:12], 12'h0}; end
            3'd5: begin f.rd = w[11:7]; f.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; end
            default: ;
        endcase
        return f;
    endfunction

    // The fields of the current request that its format actually encodes.
    function automatic fields_t norm();
        fields_t f;
        f = '0;
        f.op = in_opcode;
        case (in_fmt)
            3'd0: begin f.rd = in_rd; f.f3 = in_funct3; f.rs1 = in_rs1; f.rs2 = in_rs2; f.f7 = in_funct7; end
            3'd1: begin f.rd = in_rd; f.f3 = in_funct3; f.rs1 = in_rs1; f.imm = in_imm; end
            3'd2, 3'd3: begin f.f3 = in_funct3; f.rs1 = in_rs1; f.rs2 = in_rs2; f.imm = in_imm; end
            3'd4, 3'd5: begin f.rd = in_rd; f.imm = in_imm; end
            default: ;
        endcase
        return f;
    endfunction

    function automatic bit ref_ok(input logic [2:0] fmt, input logic [31:0] imm);
        longint v;
        v = longint'($signed(imm));
        case (fmt)
            3'd0: return 1'b1;
            3'd1, 3'd2: return v >= -2048 && v <= 2047;
            3'd3: return v >= -4096 && v <= 4094 && v % 2 == 0;
            3'd4: return imm % 4096 == 0;
            3'd5: return v >= -1048576 && v <= 1048574 && v % 2 == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic req(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        in_valid = 1'b1; in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1;
        in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    task automatic rand_req();
        logic [31:0] r;
        r = $urandom;
        req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            3'($urandom), 7'($urandom), 32'h0);
        case ($urandom_range(0, 3))
            0: in_imm = $urandom;
            1: in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: in_imm = {{11{r[20]}}, r[20:0]};
            default: in_imm = r & 32'hFFFF_F000;
        endcase
    endtask

    // Called one time unit after a rising edge with inputs set; checks, clocks once, updates the model.
    task automatic step();
        int   n;
        bit   acc, pass, pop;
        ent_t e;
        n = q.size();
        check("in_ready", in_ready, n < DEPTH);
        check("out_valid", out_valid, n != 0);
        check("fifo_level", fifo_level, n);
        check("err_range", err_range, m_pulse);
        check("err_count", err_count, m_cnt);
        if (n != 0) begin
            check("head_fields", decode(out_inst, q[0].fmt), q[0].f);
            check("head_addr", out_addr, q[0].addr);
        end
        acc = in_valid && n < DEPTH;
        pass = ref_ok(in_fmt, in_imm);
        pop = n != 0 && out_ready;
        e.fmt = in_fmt; e.f = norm(); e.addr = m_addr;
        @(posedge clk); #1;
        if (pop) void'(q.pop_front());
        if (acc && pass) begin q.push_back(e); m_addr += 4; end
        m_pulse = acc && !pass;
        if (m_pulse && m_cnt != 255) m_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_err_count", err_count, 0);
        check("rst_err_range", err_range, 0);
        check("rst_out_inst", out_inst, 0);
        check("rst_out_addr", out_addr, 0);
        q.delete(); m_addr = 0; m_cnt = 0; m_pulse = 0; in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
    endtask

    logic [2:0]  bf[16] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3,
                            3'd5, 3'd5, 3'd5, 3'd5, 3'd4, 3'd4, 3'd0, 3'd7};
    logic [31:0] bi[16] = '{32'd2047, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd2048,
                            32'd4094, 32'hFFFF_F000, 32'd4096, 32'd5,
                            32'h000F_FFFE, 32'hFFF0_0000, 32'h0010_0000, 32'd1,
                            32'h1234_5000, 32'h1234_5001, 32'hFFFF_FFFF, 32'd0};
    bit          bp[16] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0};

    initial begin
        do_reset();

        out_ready = 1'b0;
        req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        step();
        in_valid = 1'b0;
        check("i_word", out_inst, 32'hFFF0_0093);
        check("i_addr", out_addr, 32'h0);
        out_ready = 1'b1;
        step();

        do_reset();
        out_ready = 1'b0;
        req(3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'd8);
        step();
        req(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
        step();
        in_valid = 1'b0;
        check("s_word", out_inst, 32'h0021_A423);
        check("s_addr", out_addr, 32'h0);
        out_ready = 1'b1;
        step();
        check("b_word", out_inst, 32'hFE00_0EE3);
        check("b_addr", out_addr, 32'h4);
        step();

        do_reset();
        out_ready = 1'b1;
        req(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048);
        step();
        check("err_pulse_i", err_range, 1);
        req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        step();
        check("err_pulse_b", err_range, 1);
        in_valid = 1'b0;
        check("err_no_valid", out_valid, 0);
        step();
        check("err_count_2", err_count, 2);
        req(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'd100);
        step();
        in_valid = 1'b0;
        check("addr_after_err", out_addr, 32'h0);
        step();

        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req(3'd1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
            step();
        end
        check("full_in_ready", in_ready, 0);
        check("full_level", fifo_level, 4);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_addr", out_addr, 32'(i * 4));
            step();
        end
        check("drained", out_valid, 0);

        out_ready = 1'b1;
        req(3'd0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'h20, 32'd0);
        step();
        for (int i = 0; i < 6; i++) begin
            check("stream_level", fifo_level, 1);
            req(3'd1, 7'h13, 5'(i), 5'(i + 1), 5'd0, 3'(i), 7'd0, 32'(i * 3));
            step();
        end
        in_valid = 1'b0;
        step();

        for (int i = 0; i < 16; i++) begin
            req(bf[i], 7'h13, 5'd7, 5'd8, 5'd9, 3'd4, 7'd1, bi[i]);
            step();
            check("bound_err", err_range, !bp[i]);
        end
        in_valid = 1'b0;
        step();

        for (int i = 0; i < 260; i++) begin
            req(3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
            step();
        end
        in_valid = 1'b0;
        step();
        check("err_saturate", err_count, 255);

        out_ready = 1'b0;
        req(3'd4, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
        step();
        req(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        step();
        in_valid = 1'b0;
        do_reset();
        req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        step();
        in_valid = 1'b0;
        check("post_rst_addr", out_addr, 32'h0);
        out_ready = 1'b1;
        step();

        for (int i = 0; i < 400; i++) begin
            rand_req();
            in_valid = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
